fft_host_link: RTL and testbench

FFT_HOST_LINK -- requirements
Module: fft_host_link

---
 rtl/fft_host_link.sv | 188 ++++++++++++++++++
 tb/tb_fft_host_link.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_host_link.sv
// -----------------------------------------------------------------------------
// fft_host_link
//
// Host-side sequencer for an 8-point FFT block. The host loads eight unsigned
// samples and requests a frame with start. The link then resets the FFT block,
// streams the samples to it on a shared frame counter t, and collects the
// eight magnitude bins that the block presents one at a time, each marked by a
// one-hot strobe. It checks the strobe sequence and enforces a frame timeout.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   wr_en      : sample buffer write strobe (honoured only when not busy)
//   wr_addr    : sample index 0-7
//   wr_data    : unsigned sample value
//   start      : request one frame (ignored while busy)
//   busy       : frame in progress (RESET_DUT, FEED, COLLECT)
//   done       : one-cycle pulse when a frame completes successfully
//   err        : sticky error flag, cleared by the next accepted start
//   err_code   : 01 strobe not one-hot, 10 bin out of order, 11 timeout
//   rd_addr    : result bin index
//   rd_data    : combinational read of result[rd_addr]
//   dut_rst_n  : active-low reset to the FFT block
//   dut_ena    : enable to the FFT block
//   dut_ui     : sample bus to the FFT block
//   dut_uo     : magnitude bus from the FFT block
//   dut_uio    : one-hot bin strobe from the FFT block
// -----------------------------------------------------------------------------
module fft_host_link #(
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       dut_rst_n,
    output logic       dut_ena,
    output logic [7:0] dut_ui,
    input  logic [7:0] dut_uo,
    input  logic [7:0] dut_uio
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RESET_DUT = 3'd1;
    localparam logic [2:0] S_FEED      = 3'd2;
    localparam logic [2:0] S_COLLECT   = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_ERROR     = 3'd5;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_ONEHOT  = 2'b01;
    localparam logic [1:0] CODE_ORDER   = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    localparam logic [7:0] RST_LAST  = 8'(RST_CYCLES - 1);
    localparam logic [7:0] T_TIMEOUT = 8'(TIMEOUT);

    logic [2:0] state;
    logic [7:0] sample [8];
    logic [7:0] result [8];
    logic [7:0] t;
    logic [7:0] rst_cnt;
    logic [3:0] exp_bin;      // next bin expected; 8 means all captured
    logic [2:0] last_bin;     // most recently captured bin
    logic       last_valid;
    logic       done_q;
    logic [1:0] code_q;

    logic       host_owned;   // states in which the host may write / start
    logic       strobe_any;
    logic       strobe_onehot;
    logic [2:0] strobe_idx;

    assign host_owned = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

    // Strobe decode. strobe_idx is only meaningful when the strobe is one-hot.
    assign strobe_any    = (dut_uio != 8'd0);
    assign strobe_onehot = strobe_any && ((dut_uio & (dut_uio - 8'd1)) == 8'd0);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        strobe_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (dut_uio[i]) strobe_idx = 3'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            t          <= 8'd0;
            rst_cnt    <= 8'd0;
            exp_bin    <= 4'd0;
            last_bin   <= 3'd0;
            last_valid <= 1'b0;
            done_q     <= 1'b0;
            code_q     <= CODE_NONE;
            // NOTE: the sample and result arrays are reset here because the host relies on reading zeros after rst.
            for (int i = 0; i < 8; i++) begin
                sample[i] <= 8'd0;
                result[i] <= 8'd0;
            end
        end else begin
            done_q <= 1'b0;

            if (wr_en && host_owned) sample[wr_addr] <= wr_data;

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state      <= S_RESET_DUT;
                        rst_cnt    <= 8'd0;
                        t          <= 8'd0;
                        code_q     <= CODE_NONE;
                        exp_bin    <= 4'd0;
                        last_valid <= 1'b0;
                        for (int i = 0; i < 8; i++) result[i] <= 8'd0;
                    end
                end

                S_RESET_DUT: begin
                    if (rst_cnt == RST_LAST) begin
                        state <= S_FEED;
                        t     <= 8'd0;
                    end else begin
                        rst_cnt <= rst_cnt + 8'd1;
                    end
                end

                S_FEED: begin
                    t <= t + 8'd1;
                    if (t == 8'd31) state <= S_COLLECT;
                end

                S_COLLECT: begin
                    t <= t + 8'd1;
                    // Strobe errors outrank both completion and timeout.
                    if (strobe_any && !strobe_onehot) begin
                        state  <= S_ERROR;
                        code_q <= CODE_ONEHOT;
                    end else if (!strobe_any && exp_bin == 4'd8) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end else if (t == T_TIMEOUT) begin
                        state  <= S_ERROR;
                        code_q <= CODE_TIMEOUT;
                    end else if (strobe_any) begin
                        if (exp_bin != 4'd8 && strobe_idx == exp_bin[2:0]) begin
                            result[strobe_idx] <= dut_uo;
                            exp_bin            <= exp_bin + 4'd1;
                            last_bin           <= strobe_idx;
                            last_valid         <= 1'b1;
                        end else if (!(last_valid && strobe_idx == last_bin)) begin
                            // A repeat of the last bin is the same strobe held over
                            // several cycles; anything else is out of order.
                            state  <= S_ERROR;
                            code_q <= CODE_ORDER;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state == S_RESET_DUT) || (state == S_FEED) || (state == S_COLLECT);
    assign dut_ena   = (state == S_FEED) || (state == S_COLLECT);
    // The FFT block stays in reset from rst until a start has run RESET_DUT.
    assign dut_rst_n = !((state == S_IDLE) || (state == S_RESET_DUT));
    // The block latches sample k at t=4k, so each sample is held for 4 cycles.
    assign dut_ui    = (dut_ena && t < 8'd32) ? sample[t[4:2]] : 8'd0;
    assign done      = done_q;
    assign err       = (state == S_ERROR);
    assign err_code  = code_q;
    assign rd_data   = result[rd_addr];

endmodule

// File: tb/tb_fft_host_link.sv
// -----------------------------------------------------------------------------
// tb_fft_host_link
//
// Directed bench for fft_host_link with a behavioural FFT responder. The
// responder is driven from the bench's own frame counter, which starts at the
// first cycle after RESET_DUT; expected values come from a vector table.
// -----------------------------------------------------------------------------
module tb_fft_host_link;

    localparam int RST_CYCLES = 2;
    localparam int TIMEOUT    = 200;

    // Responder modes
    localparam int M_NORMAL = 0;   // bins 0-7 at t=100+4k, then clear
    localparam int M_ONEHOT = 1;   // bin 0, then 0x03 at t=104
    localparam int M_ORDER  = 2;   // bin 0, then bin 2
    localparam int M_SILENT = 3;   // never strobes
    localparam int M_ABORT  = 4;   // silent, host pokes during busy, rst at t=50

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [2:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       dut_rst_n;
    logic       dut_ena;
    logic [7:0] dut_ui;
    logic [7:0] dut_uo = '0;
    logic [7:0] dut_uio = '0;

    int checks = 0;
    int failures = 0;

    fft_host_link #(.RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .dut_rst_n (dut_rst_n),
        .dut_ena   (dut_ena),
        .dut_ui    (dut_ui),
        .dut_uo    (dut_uo),
        .dut_uio   (dut_uio)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int         mode;
        int         t;
        logic [7:0] ui;
        logic       busy;
        logic       done;
        logic       ena;
        logic       rstn;
        logic       err;
        logic [1:0] code;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 8'(busy), 8'd0);
        check({tag, "_done"}, 8'(done), 8'd0);
        check({tag, "_err"}, 8'(err), 8'd0);
        check({tag, "_code"}, 8'(err_code), 8'd0);
        check({tag, "_rstn"}, 8'(dut_rst_n), 8'd0);
        check({tag, "_ena"}, 8'(dut_ena), 8'd0);
        check({tag, "_ui"}, dut_ui, 8'd0);
    endtask

    // Issue start from a host-owned state; returns in frame cycle t=0.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        rd_addr = 3'd0;
        #1;
        check("start_busy", 8'(busy), 8'd1);
        check("start_rstn", 8'(dut_rst_n), 8'd0);
        check("start_ena", 8'(dut_ena), 8'd0);
        check("start_err_clr", 8'(err), 8'd0);
        check("start_code_clr", 8'(err_code), 8'd0);
        check("start_res_clr", rd_data, 8'd0);
        for (int i = 1; i < RST_CYCLES; i++) begin
            tick();
            check("rstdut_rstn", 8'(dut_rst_n), 8'd0);
            check("rstdut_ena", 8'(dut_ena), 8'd0);
        end
        tick();
    endtask

    task automatic respond(input int mode, input int t);
        dut_uio = 8'd0;
        dut_uo  = 8'd0;
        case (mode)
            M_NORMAL: if (t >= 100 && t < 132) begin
                dut_uio = 8'd1 << ((t - 100) / 4);
                dut_uo  = 8'(8'h11 * ((t - 100) / 4 + 1));
            end
            M_ONEHOT: begin
                if (t >= 100 && t < 104) begin dut_uio = 8'h01; dut_uo = 8'h11; end
                if (t == 104) begin dut_uio = 8'h03; dut_uo = 8'h22; end
            end
            M_ORDER: begin
                if (t >= 100 && t < 104) begin dut_uio = 8'h01; dut_uo = 8'h11; end
                if (t >= 104 && t < 108) begin dut_uio = 8'h04; dut_uo = 8'h33; end
            end
            default: ;
        endcase
    endtask

    // Runs frame cycles 0..stop_t, comparing every table entry for this mode.
    task automatic run_frame(input int mode, input int stop_t);
        for (int t = 0; t <= stop_t; t++) begin
            respond(mode, t);
            // Host pokes while busy; both must be ignored.
            wr_en   = ((mode == M_ONEHOT || mode == M_ABORT) && t == 20);
            wr_addr = (mode == M_ONEHOT) ? 3'd7 : 3'd0;
            wr_data = (mode == M_ONEHOT) ? 8'hEE : 8'hFF;
            start   = ((mode == M_ONEHOT && t == 40) || (mode == M_ABORT && t == 30));
            #1;
            foreach (vecs[i]) begin
                if (vecs[i].mode == mode && vecs[i].t == t) begin
                    check($sformatf("m%0d_t%0d_ui", mode, t), dut_ui, vecs[i].ui);
                    check($sformatf("m%0d_t%0d_busy", mode, t), 8'(busy), 8'(vecs[i].busy));
                    check($sformatf("m%0d_t%0d_done", mode, t), 8'(done), 8'(vecs[i].done));
                    check($sformatf("m%0d_t%0d_ena", mode, t), 8'(dut_ena), 8'(vecs[i].ena));
                    check($sformatf("m%0d_t%0d_rstn", mode, t), 8'(dut_rst_n), 8'(vecs[i].rstn));
                    check($sformatf("m%0d_t%0d_err", mode, t), 8'(err), 8'(vecs[i].err));
                    check($sformatf("m%0d_t%0d_code", mode, t), 8'(err_code), 8'(vecs[i].code));
                end
            end
            tick();
            wr_en = 1'b0;
            start = 1'b0;
        end
        dut_uio = 8'd0;
        dut_uo  = 8'd0;
    endtask

    initial begin
        //                 mode      t    ui   busy done ena rstn err code
        vecs.push_back('{M_NORMAL,   0, 8'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_NORMAL,   3, 8'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_NORMAL,   4, 8'd20, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_NORMAL,  17, 8'd50, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_NORMAL,  31, 8'd80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_NORMAL,  32, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_NORMAL, 132, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_NORMAL, 133, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_NORMAL, 134, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_ONEHOT,  41, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_ONEHOT, 104, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_ONEHOT, 105, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1});
        vecs.push_back('{M_ONEHOT, 107, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1});
        vecs.push_back('{M_ORDER,   28, 8'd80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_ORDER,  105, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2});
        vecs.push_back('{M_SILENT, 200, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{M_SILENT, 201, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3});
        vecs.push_back('{M_SILENT, 202, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3});
        vecs.push_back('{M_ABORT,   31, 8'd80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0});

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("por");
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            #1;
            check($sformatf("por_res%0d", k), rd_data, 8'd0);
        end

        // Load samples 10..80 in IDLE
        for (int k = 0; k < 8; k++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(k);
            wr_data = 8'(10 * (k + 1));
            tick();
        end
        wr_en = 1'b0;

        // Normal frame, then read every bin
        do_start();
        run_frame(M_NORMAL, 135);
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            #1;
            check($sformatf("norm_res%0d", k), rd_data, 8'(8'h11 * (k + 1)));
        end

        // Strobe not one-hot: bin 0 retained, bin 1 unwritten
        do_start();
        run_frame(M_ONEHOT, 107);
        rd_addr = 3'd0;
        #1;
        check("onehot_res0", rd_data, 8'h11);
        rd_addr = 3'd1;
        #1;
        check("onehot_res1", rd_data, 8'd0);

        // Out-of-order bin (also confirms the busy-time write to sample 7 was dropped)
        do_start();
        run_frame(M_ORDER, 107);
        rd_addr = 3'd2;
        #1;
        check("order_res2", rd_data, 8'd0);

        // Timeout
        do_start();
        run_frame(M_SILENT, 202);

        // Mid-frame rst after ignored busy-time write and start
        do_start();
        run_frame(M_ABORT, 49);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick();
        check("abort_rstn_hold", 8'(dut_rst_n), 8'd0);
        check("abort_busy_hold", 8'(busy), 8'd0);

        // Samples were cleared by rst: a new frame feeds zeros
        do_start();
        check("post_rst_ui0", dut_ui, 8'd0);
        check("post_rst_ena", 8'(dut_ena), 8'd1);
        check("post_rst_rstn", 8'(dut_rst_n), 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
